// File: rtl/pixel_pingpong_buffer.sv
// Double-banked pixel frame buffer: the producer fills one bank while the consumer drains the other.
// Define PIXEL_PINGPONG_DROP_EN to never stall the producer and drop words while both banks are busy.
module pixel_pingpong_buffer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_enable,
   input  logic              pause,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              frame_done,
   output logic              read_done,
   output logic              overflow
);

   typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   bank_state_e       state_q [2];
   bank_state_e       state_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              read_done_q, read_done_d;
   logic              overflow_q, overflow_d;

   logic [DATA_W-1:0] mem [2][DEPTH];

   logic              consume;
   logic              last_consume;
   logic              can_write;
   logic              wr_fire;
   logic              fetch;
   logic              fetch_bank;
   logic [ADDR_W-1:0] fetch_ptr;

   // rd_ptr addresses the presented word while rd_valid is high, else the next word to fetch.
   always_comb begin
      consume      = rd_valid_q && !pause;
      last_consume = consume && (rd_ptr_q == LastAddr);
      // A bank releasing its last word this cycle may take the first word of the next frame.
      can_write    = (state_q[wr_bank_q] == StEmpty) || (state_q[wr_bank_q] == StFilling) ||
                     ((state_q[wr_bank_q] == StDraining) && last_consume);
      wr_fire      = wr_valid && can_write && !clear;

      if (!rd_valid_q) begin
         fetch_bank = rd_bank_q;
         fetch_ptr  = rd_ptr_q;
      end else if (rd_ptr_q == LastAddr) begin
         fetch_bank = ~rd_bank_q;
         fetch_ptr  = '0;
      end else begin
         fetch_bank = rd_bank_q;
         fetch_ptr  = rd_ptr_q + 1'b1;
      end
      fetch = !pause && rd_enable &&
              ((state_q[fetch_bank] == StFull) || (state_q[fetch_bank] == StDraining));
   end

`ifdef PIXEL_PINGPONG_DROP_EN
   assign wr_ready = 1'b1;
`else
   assign wr_ready = can_write;
`endif

   always_comb begin
      state_d      = state_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = rd_valid_q;
      frame_done_d = 1'b0;
      read_done_d  = 1'b0;
      overflow_d   = overflow_q;

      if (consume) begin
         if (rd_ptr_q == LastAddr) begin
            state_d[rd_bank_q] = StEmpty;
            read_done_d        = 1'b1;
            rd_ptr_d           = '0;
            rd_bank_d          = ~rd_bank_q;
         end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end

      if (fetch) begin
         rd_valid_d = 1'b1;
         rd_data_d  = mem[fetch_bank][fetch_ptr];
         if (state_q[fetch_bank] == StFull) begin
            state_d[fetch_bank] = StDraining;
         end
      end else if (consume) begin
         rd_valid_d = 1'b0;
      end

      // Applied after the read side so a refill of a just-emptied bank wins.
      if (wr_fire) begin
         if (wr_ptr_q == LastAddr) begin
            state_d[wr_bank_q] = StFull;
            frame_done_d       = 1'b1;
            wr_ptr_d           = '0;
            wr_bank_d          = ~wr_bank_q;
         end else begin
            state_d[wr_bank_q] = StFilling;
            wr_ptr_d           = wr_ptr_q + 1'b1;
         end
      end

      if (wr_valid && !can_write) begin
         overflow_d = 1'b1;
      end

      if (clear) begin
         state_d      = '{StEmpty, StEmpty};
         wr_bank_d    = 1'b0;
         rd_bank_d    = 1'b0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         rd_data_d    = '0;
         rd_valid_d   = 1'b0;
         frame_done_d = 1'b0;
         read_done_d  = 1'b0;
         overflow_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= '{StEmpty, StEmpty};
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
         read_done_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         frame_done_q <= frame_done_d;
         read_done_q  <= read_done_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_bank_q][wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign frame_done = frame_done_q;
   assign read_done  = read_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_pingpong_buffer.sv
// Directed bench for pixel_pingpong_buffer (DEPTH=4) with a queue scoreboard of written pixels.
module tb_pixel_pingpong_buffer;

   localparam int unsigned DataW = 8;
   localparam int unsigned Depth = 4;
   localparam int unsigned AddrW = 2;
`ifdef PIXEL_PINGPONG_DROP_EN
   localparam bit DropEn = 1'b1;
`else
   localparam bit DropEn = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             wr_valid;
   logic [DataW-1:0] wr_data;
   logic             wr_ready;
   logic             rd_enable;
   logic             pause;
   logic [DataW-1:0] rd_data;
   logic             rd_valid;
   logic             frame_done;
   logic             read_done;
   logic             overflow;

   logic [DataW-1:0] exp_q [$];
   int vectors     = 0;
   int miscompares = 0;
   int fd_cnt      = 0;
   int rd_cnt      = 0;
   int ready_low   = 0;
   int both_cnt    = 0;

   pixel_pingpong_buffer #(
      .DATA_W (DataW),
      .DEPTH  (Depth),
      .ADDR_W (AddrW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .rd_enable  (rd_enable),
      .pause      (pause),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .frame_done (frame_done),
      .read_done  (read_done),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: settle, score the consumed word and pulses, then advance to the next negedge.
   task automatic cycle();
      #1;
      if (rd_valid === 1'b1 && pause === 1'b0) begin
         if (exp_q.size() == 0) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL sb_underflow: observed data %0h expected no word", rd_data);
            end
         end else begin
            check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
         end
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (read_done === 1'b1) rd_cnt++;
      if (frame_done === 1'b1 && read_done === 1'b1) both_cnt++;
      if (wr_ready !== 1'b1) ready_low++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic write_word(input logic [DataW-1:0] d, input bit keep);
      wr_valid = 1'b1;
      wr_data  = d;
      if (keep) exp_q.push_back(d);
      cycle();
      wr_valid = 1'b0;
   endtask

   task automatic reset_counts();
      fd_cnt    = 0;
      rd_cnt    = 0;
      ready_low = 0;
      both_cnt  = 0;
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rd_enable = 1'b0;
      pause     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_wr_ready", wr_ready, 1);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_read_done", read_done, 0);
      check("rst_overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frame with rd_enable already high.
      rd_enable = 1'b1;
      for (int i = 0; i < 4; i++) write_word(8'h10 + 8'(i), 1'b1);
      #1;
      check("t1_frame_done", frame_done, 1);
      check("t1_rd_valid_early", rd_valid, 0);
      cycle();
      #1;
      check("t1_rd_valid_latency", rd_valid, 1);
      idle(4);
      #1;
      check("t1_read_done", read_done, 1);
      check("t1_rd_valid_end", rd_valid, 0);
      check("t1_q_empty", exp_q.size(), 0);
      idle(1);

      // Both banks full, producer back-pressured, then back-to-back drain.
      rd_enable = 1'b0;
      for (int i = 0; i < 8; i++) write_word(8'h20 + 8'(i), 1'b1);
      #1;
      check("t2_wr_ready_full", wr_ready, DropEn ? 1 : 0);
      check("t2_overflow_clean", overflow, 0);
      write_word(8'h28, 1'b0);
      #1;
      check("t2_overflow_set", overflow, 1);
      reset_counts();
      rd_enable = 1'b1;
      cycle();
      for (int i = 0; i < 8; i++) begin
         #1;
         check("t2_no_bubble", rd_valid, 1);
         cycle();
      end
      #1;
      check("t2_rd_valid_end", rd_valid, 0);
      cycle();
      check("t2_read_done_cnt", rd_cnt, 2);
      check("t2_q_empty", exp_q.size(), 0);

      // Pause held for three cycles on the second word.
      rd_enable = 1'b0;
      for (int i = 0; i < 4; i++) write_word(8'h30 + 8'(i), 1'b1);
      rd_enable = 1'b1;
      idle(2);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_pause_data", rd_data, 8'h31);
         check("t3_pause_valid", rd_valid, 1);
         cycle();
      end
      pause = 1'b0;
      idle(3);
      #1;
      check("t3_rd_valid_end", rd_valid, 0);
      check("t3_q_empty", exp_q.size(), 0);
      idle(1);

      // Continuous streaming, 16 words.
      reset_counts();
      for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i), 1'b1);
      check("t4_no_stall", ready_low, 0);
      idle(8);
      check("t4_frame_done_cnt", fd_cnt, 4);
      check("t4_read_done_cnt", rd_cnt, 4);
      check("t4_q_empty", exp_q.size(), 0);

      // Final write of one bank coincides with final consume of the other.
      rd_enable = 1'b0;
      for (int i = 0; i < 7; i++) write_word(8'h50 + 8'(i), 1'b1);
      rd_enable = 1'b1;
      idle(4);
      write_word(8'h57, 1'b1);
      #1;
      check("t5_frame_done", frame_done, 1);
      check("t5_read_done", read_done, 1);
      check("t5_wr_ready", wr_ready, 1);
      idle(6);
      check("t5_q_empty", exp_q.size(), 0);

      // Clear mid-frame while a word is held on the output.
      rd_enable = 1'b0;
      for (int i = 0; i < 6; i++) write_word(8'h60 + 8'(i), 1'b0);
      rd_enable = 1'b1;
      cycle();
      pause = 1'b1;
      #1;
      check("t6_pre_rd_valid", rd_valid, 1);
      check("t6_pre_overflow", overflow, 1);
      clear    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      cycle();
      clear    = 1'b0;
      wr_valid = 1'b0;
      pause    = 1'b0;
      #1;
      check("t6_clr_rd_valid", rd_valid, 0);
      check("t6_clr_overflow", overflow, 0);
      check("t6_clr_wr_ready", wr_ready, 1);
      for (int i = 0; i < 4; i++) write_word(8'h70 + 8'(i), 1'b1);
      idle(6);
      check("t6_q_empty", exp_q.size(), 0);

`ifdef PIXEL_PINGPONG_DROP_EN
      // Free-running producer: words beyond two banks are dropped.
      rd_enable = 1'b0;
      reset_counts();
      for (int i = 0; i < 12; i++) write_word(8'h80 + 8'(i), i < 8);
      check("t7_no_stall", ready_low, 0);
      #1;
      check("t7_overflow", overflow, 1);
      rd_enable = 1'b1;
      idle(12);
      check("t7_q_empty", exp_q.size(), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
